// File: rtl/controller_spi_tx.sv
// Controller-side two-wire link transmitter: snapshots buttons and joystick X/Y,
// then repeats {SYNC_BYTE, buttons, x, y} MSB-first on chip_clk/chip_data.
module controller_spi_tx #(
    parameter int unsigned CLK_DIV    = 50,
    parameter int unsigned GAP_CYCLES = 1000,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       enable_in,
    input  logic [7:0] buttons_in,
    input  logic [7:0] joystick_x_in,
    input  logic [7:0] joystick_y_in,
    output logic       chip_clk_out,
    output logic       chip_data_out,
    output logic       busy_out,
    output logic       frame_done_out
);

    localparam int unsigned PH_W  = $clog2(2 * CLK_DIV);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } state_t;

    state_t            state;
    logic [31:0]       shreg;
    logic [4:0]        bit_cnt;
    logic [PH_W-1:0]   phase;
    logic [GAP_W-1:0]  gap_cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            shreg          <= '0;
            bit_cnt        <= '0;
            phase          <= '0;
            gap_cnt        <= '0;
            chip_clk_out   <= 1'b0;
            chip_data_out  <= 1'b0;
            busy_out       <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            frame_done_out <= 1'b0;
            case (state)
                IDLE: begin
                    chip_clk_out  <= 1'b0;
                    chip_data_out <= 1'b0;
                    if (enable_in) begin
                        state    <= LOAD;
                        busy_out <= 1'b1;
                    end
                end

                LOAD: begin
                    shreg         <= {SYNC_BYTE, buttons_in, joystick_x_in, joystick_y_in};
                    bit_cnt       <= 5'd31;
                    phase         <= '0;
                    chip_data_out <= SYNC_BYTE[7];
                    state         <= SHIFT;
                end

                SHIFT: begin
                    phase <= phase + 1'b1;
                    // Data moves one cycle after chip_clk falls so it never
                    // changes on the same edge as any chip_clk transition.
                    if (phase == '0) begin
                        chip_data_out <= shreg[31];
                    end
                    if (phase == PH_RISE) begin
                        chip_clk_out <= 1'b1;
                    end
                    if (phase == PH_LAST) begin
                        chip_clk_out <= 1'b0;
                        phase        <= '0;
                        shreg        <= {shreg[30:0], 1'b0};
                        bit_cnt      <= bit_cnt - 1'b1;
                        if (bit_cnt == '0) begin
                            frame_done_out <= 1'b1;
                            gap_cnt        <= '0;
                            state          <= GAP;
                        end
                    end
                end

                GAP: begin
                    chip_clk_out  <= 1'b0;
                    chip_data_out <= 1'b0;
                    gap_cnt       <= gap_cnt + 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        if (enable_in) begin
                            state <= LOAD;
                        end else begin
                            state    <= IDLE;
                            busy_out <= 1'b0;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controller_spi_tx.sv
// Bench for controller_spi_tx: a default-parameter instance and a fast instance
// (CLK_DIV=2, GAP_CYCLES=1), each checked every cycle against a timeline model.
module tb_controller_spi_tx;

    localparam int C0 = 50;
    localparam int G0 = 1000;
    localparam int C1 = 2;
    localparam int G1 = 1;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int S_CK = 0;
    localparam int S_DT = 1;
    localparam int S_BZ = 2;
    localparam int S_FD = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst;
    logic [1:0] en;
    logic [7:0] btn [2];
    logic [7:0] jx  [2];
    logic [7:0] jy  [2];
    logic [1:0] ck, dt, bz, fd;

    controller_spi_tx #(.CLK_DIV(C0), .GAP_CYCLES(G0), .SYNC_BYTE(SYNC)) u_dut0 (
        .clk_in(clk), .rst_in(rst[0]), .enable_in(en[0]),
        .buttons_in(btn[0]), .joystick_x_in(jx[0]), .joystick_y_in(jy[0]),
        .chip_clk_out(ck[0]), .chip_data_out(dt[0]),
        .busy_out(bz[0]), .frame_done_out(fd[0])
    );

    controller_spi_tx #(.CLK_DIV(C1), .GAP_CYCLES(G1), .SYNC_BYTE(SYNC)) u_dut1 (
        .clk_in(clk), .rst_in(rst[1]), .enable_in(en[1]),
        .buttons_in(btn[1]), .joystick_x_in(jx[1]), .joystick_y_in(jy[1]),
        .chip_clk_out(ck[1]), .chip_data_out(dt[1]),
        .busy_out(bz[1]), .frame_done_out(fd[1])
    );

    // Model: position k within a frame timeline, k=0 is the LOAD cycle.
    bit          m_act  [2];
    int          m_k    [2];
    logic [31:0] m_word [2];
    logic [3:0]  exp_v  [2];

    function automatic int cdiv(input int i);
        return (i == 0) ? C0 : C1;
    endfunction

    function automatic int gcyc(input int i);
        return (i == 0) ? G0 : G1;
    endfunction

    // Expected {chip_clk, chip_data, busy, frame_done} at timeline position k.
    function automatic logic [3:0] model_out(input bit act, input int k, input logic [31:0] w, input int c);
        int b;
        int p;
        if (!act) return 4'b0000;
        if (k == 0) return 4'b0010;
        if (k <= 64 * c) begin
            b = (k - 1) / (2 * c);
            p = (k - 1) % (2 * c);
            return {(p >= c), ((p == 0) && (b > 0)) ? w[32 - b] : w[31 - b], 1'b1, 1'b0};
        end
        if (k == 64 * c + 1) return {1'b0, w[0], 1'b1, 1'b1};
        return 4'b0010;
    endfunction

    always @(posedge clk) begin : model_blk
        bit          a;
        int          k;
        logic [31:0] w;
        for (int i = 0; i < 2; i++) begin
            a = m_act[i];
            k = m_k[i];
            w = m_word[i];
            if (!rst[i]) begin
                a = 1'b0;
                k = 0;
            end else if (!a) begin
                if (en[i]) begin
                    a = 1'b1;
                    k = 0;
                end
            end else begin
                k = k + 1;
                if (k == 1) w = {SYNC, btn[i], jx[i], jy[i]};
                if (k == 1 + 64 * cdiv(i) + gcyc(i)) begin
                    if (en[i]) k = 0;
                    else a = 1'b0;
                end
            end
            m_act[i]  <= a;
            m_k[i]    <= k;
            m_word[i] <= w;
            exp_v[i]  <= model_out(a, k, w, cdiv(i));
        end
    end

    // Receiver-side decode: sample data on chip_clk rise, latch word on frame_done.
    logic [31:0] dec_sr [2];
    int          dec_n  [2] = '{0, 0};
    logic [31:0] dec_w  [2][8];
    int          dec_nb [2][8];
    int          dec_cnt[2] = '{0, 0};
    logic [1:0]  ck_p  = '0;
    logic [1:0]  dt_p  = '0;
    logic [1:0]  rst_p = '0;
    int          viol  [2] = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst[i]) begin
                dec_n[i] <= 0;
            end else begin
                if (ck[i] && !ck_p[i]) begin
                    dec_sr[i] <= {dec_sr[i][30:0], dt[i]};
                    dec_n[i]  <= dec_n[i] + 1;
                end
                if (fd[i]) begin
                    dec_w[i][dec_cnt[i] % 8]  <= dec_sr[i];
                    dec_nb[i][dec_cnt[i] % 8] <= dec_n[i];
                    dec_cnt[i] <= dec_cnt[i] + 1;
                    dec_n[i]   <= 0;
                end
            end
        end
    end

    // Data may only change across an edge where chip_clk is low on both sides.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_p[i] === 1'b1 && dt[i] !== dt_p[i] && (ck[i] !== 1'b0 || ck_p[i] !== 1'b0))
                viol[i] <= viol[i] + 1;
        end
        ck_p  <= ck;
        dt_p  <= dt;
        rst_p <= rst;
    end

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++)
            chk($sformatf("outs%0d_cyc%0d", i, cyc), {28'b0, ck[i], dt[i], bz[i], fd[i]}, {28'b0, exp_v[i]});
    endtask

    function automatic logic sig(input int i, input int s);
        case (s)
            S_CK:    return ck[i];
            S_DT:    return dt[i];
            S_BZ:    return bz[i];
            default: return fd[i];
        endcase
    endfunction

    task automatic wait_sig(input string name, input int i, input int s, input logic v,
                            input int limit, output int n);
        n = 0;
        while (sig(i, s) !== v && n < limit) begin
            tick();
            n++;
        end
        chk(name, {31'b0, sig(i, s)}, {31'b0, v});
    endtask

    initial begin
        int n, n1, n2, t;
        rst = '0;
        en  = '0;
        for (int i = 0; i < 2; i++) begin
            btn[i] = '0;
            jx[i]  = '0;
            jy[i]  = '0;
        end
        repeat (3) tick();
        chk("reset_outs0", {28'b0, ck[0], dt[0], bz[0], fd[0]}, 32'h0);
        chk("reset_outs1", {28'b0, ck[1], dt[1], bz[1], fd[1]}, 32'h0);
        rst[0] = 1'b1;
        repeat (2) tick();

        // Frame 1 with inputs changed mid-SHIFT, then frame 2 carrying the new values.
        btn[0] = 8'h81; jx[0] = 8'h7F; jy[0] = 8'h00; en[0] = 1'b1;
        wait_sig("t1_busy", 0, S_BZ, 1'b1, 10, n);
        chk("t1_busy_lat", n, 1);
        repeat (100) tick();
        btn[0] = 8'hFF; jx[0] = 8'hFF; jy[0] = 8'hFF;
        wait_sig("t1_done", 0, S_FD, 1'b1, 5000, n);
        chk("t1_load_to_done", n + 100, 3201);
        tick();
        chk("t1_word_cnt", dec_cnt[0], 1);
        chk("t1_word", dec_w[0][0], 32'hA5817F00);
        chk("t1_bits", dec_nb[0][0], 32);

        // Drop enable during byte 2 of frame 2.
        repeat (2199) tick();
        en[0] = 1'b0;
        wait_sig("t3_done", 0, S_FD, 1'b1, 5000, n);
        wait_sig("t3_idle", 0, S_BZ, 1'b0, 2000, n);
        chk("t3_gap_len", n, G0);
        chk("t3_word_cnt", dec_cnt[0], 2);
        chk("t3_word", dec_w[0][1], 32'hA5FFFFFF);
        repeat (50) tick();
        chk("t3_idle_outs", {28'b0, ck[0], dt[0], bz[0], fd[0]}, 32'h0);
        chk("t3_no_new_frame", dec_cnt[0], 2);

        // Reset for one cycle while chip_clk is high; a fresh frame follows.
        btn[0] = 8'h12; jx[0] = 8'h34; jy[0] = 8'h56; en[0] = 1'b1;
        wait_sig("t4_busy", 0, S_BZ, 1'b1, 10, n);
        repeat (300) tick();
        wait_sig("t4_ck_high", 0, S_CK, 1'b1, 200, n);
        rst[0] = 1'b0;
        btn[0] = 8'h9A; jx[0] = 8'hBC; jy[0] = 8'hDE;
        tick();
        chk("t4_reset_outs", {28'b0, ck[0], dt[0], bz[0], fd[0]}, 32'h0);
        rst[0] = 1'b1;
        wait_sig("t4_restart", 0, S_BZ, 1'b1, 10, n);
        chk("t4_restart_lat", n, 1);
        wait_sig("t4_done", 0, S_FD, 1'b1, 5000, n);
        chk("t4_load_to_done", n, 3201);
        tick();
        chk("t4_word_cnt", dec_cnt[0], 3);
        chk("t4_word", dec_w[0][2], 32'hA59ABCDE);
        chk("t4_bits", dec_nb[0][2], 32);
        en[0] = 1'b0;
        wait_sig("t4_idle", 0, S_BZ, 1'b0, 2000, n);

        // Fast instance, enable held for three frames.
        rst[1] = 1'b1;
        btn[1] = 8'hC3; jx[1] = 8'h3C; jy[1] = 8'h5A; en[1] = 1'b1;
        wait_sig("t5_busy", 1, S_BZ, 1'b1, 10, n);
        wait_sig("t5_first_rise", 1, S_CK, 1'b1, 20, n);
        chk("t5_first_rise_lat", n, 3);
        t = n;
        wait_sig("t5_ck_fall", 1, S_CK, 1'b0, 20, n1);
        wait_sig("t5_ck_rise", 1, S_CK, 1'b1, 20, n2);
        chk("t5_ck_period", n1 + n2, 4);
        wait_sig("t5_done1", 1, S_FD, 1'b1, 300, n);
        chk("t5_load_to_done", t + n1 + n2 + n, 129);
        wait_sig("t5_fd_low", 1, S_FD, 1'b0, 10, n1);
        wait_sig("t5_done2", 1, S_FD, 1'b1, 300, n2);
        chk("t5_frame_spacing", n1 + n2, 130);
        wait_sig("t5_fd_low2", 1, S_FD, 1'b0, 10, n1);
        wait_sig("t5_done3", 1, S_FD, 1'b1, 300, n2);
        en[1] = 1'b0;
        wait_sig("t5_idle", 1, S_BZ, 1'b0, 20, n);
        chk("t5_idle_lat", n, 1);
        chk("t5_word_cnt", dec_cnt[1], 3);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("t5_word%0d", j), dec_w[1][j], 32'hA5C33C5A);
            chk($sformatf("t5_bits%0d", j), dec_nb[1][j], 32);
        end
        repeat (5) tick();

        chk("data_vs_clk_rule0", viol[0], 0);
        chk("data_vs_clk_rule1", viol[1], 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
